// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared default sizing for the byte FIFO and its storage sub-block.
//   FIFO_DATA_WIDTH : width of din/dout
//   FIFO_DEPTH      : number of storage entries (power of two)
//   FIFO_ADDR_WIDTH : pointer width, log2(FIFO_DEPTH)
//   FIFO_CNT_WIDTH  : occupancy counter width, holds 0..FIFO_DEPTH inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int FIFO_CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fifo_if.sv
// -----------------------------------------------------------------------------
// fifo_if
// Producer/consumer side of the FIFO grouped into one bundle.
//   wr, rd, din          : requests and write data (driven by the master)
//   dout                 : registered read data (driven by the FIFO)
//   full, empty          : occupancy status decodes (driven by the FIFO)
//   fifo_cnt             : number of stored entries (driven by the FIFO)
// Modports: master = user of the queue, slave = the FIFO itself.
// -----------------------------------------------------------------------------
interface fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
);

   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic [CNT_WIDTH-1:0]  fifo_cnt;

   modport master (
      output wr, rd, din,
      input  dout, full, empty, fifo_cnt
   );

   modport slave (
      input  wr, rd, din,
      output dout, full, empty, fifo_cnt
   );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Small register-file RAM: one synchronous write port, one synchronous read
// port whose output register holds its value when no read is requested.
//   clk   : clock
//   reset : asynchronous active-high reset (clears the read register only)
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable, mem[raddr] loaded into rdata on the rising edge
//   rdata : registered read data
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   // Storage is deliberately left out of reset so it can map onto RAM cells.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Synchronous single-clock byte FIFO with full/empty/occupancy status.
//   clk   : clock, all state updates on its rising edge
//   reset : asynchronous active-high reset
//   bus   : fifo_if slave port (wr, rd, din in; dout, full, empty, fifo_cnt out)
// Writes while full and reads while empty are silently ignored. A read and a
// write on the same edge both proceed unless one of them is blocked by the
// current full/empty state.
// -----------------------------------------------------------------------------
module fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
   input  logic  clk,
   input  logic  reset,
   fifo_if.slave bus
);

   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic                  full;
   logic                  empty;
   logic                  write_en;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] dout;

   // Status is a pure decode of the counter, so full and empty are exclusive.
   assign full     = (cnt_q == CNT_WIDTH'(DEPTH));
   assign empty    = (cnt_q == '0);

   // Acceptance uses pre-edge status: a read on empty never sees this edge's
   // write, and a write on full is dropped even if a read frees a slot.
   assign write_en = bus.wr & ~full;
   assign read_en  = bus.rd & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
      if (write_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (read_en) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({write_en, read_en})
         2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
         2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (write_en),
      .waddr (wr_ptr_q),
      .wdata (bus.din),
      .re    (read_en),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

   assign bus.dout     = dout;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.fifo_cnt = cnt_q;

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo
// Self-checking bench for the byte FIFO: a vector table of per-edge requests
// with expected count/status, a reference queue producing expected dout
// values, and hand-written sequences for reset behaviour.
// -----------------------------------------------------------------------------
module tb_fifo;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] din;
      logic [3:0] exp_cnt;
      logic       exp_full;
      logic       exp_empty;
   } vec_t;

   logic clk;
   logic reset;

   int checks   = 0;
   int failures = 0;

   vec_t       vecs[$];
   logic [7:0] model_q[$];   // reference FIFO contents
   logic [7:0] exp_q[$];     // expected dout values awaiting the DUT
   logic [7:0] last_dout;

   fifo_if bus ();

   fifo dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] din, input int cnt);
      vec_t v;
      v.wr        = wr;
      v.rd        = rd;
      v.din       = din;
      v.exp_cnt   = 4'(cnt);
      v.exp_full  = (cnt == 8);
      v.exp_empty = (cnt == 0);
      return v;
   endfunction

   function automatic void add(input logic wr, input logic rd, input logic [7:0] din, input int cnt);
      vecs.push_back(mk(wr, rd, din, cnt));
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Drive one request set for one edge, update the reference model with the
   // pre-edge acceptance rules, then compare everything just after the edge.
   task automatic apply(input vec_t v, input int idx);
      bit m_we;
      bit m_re;
      @(negedge clk);
      bus.wr  = v.wr;
      bus.rd  = v.rd;
      bus.din = v.din;
      m_we = v.wr && (model_q.size() < 8);
      m_re = v.rd && (model_q.size() != 0);
      if (m_re) exp_q.push_back(model_q.pop_front());
      if (m_we) model_q.push_back(v.din);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) last_dout = exp_q.pop_front();
      $display("vec %0d wr=%0b rd=%0b din=%02h -> cnt=%0d full=%0b empty=%0b dout=%02h",
               idx, v.wr, v.rd, v.din, bus.fifo_cnt, bus.full, bus.empty, bus.dout);
      check("cnt",   idx, 32'(bus.fifo_cnt), 32'(v.exp_cnt));
      check("full",  idx, 32'(bus.full),     32'(v.exp_full));
      check("empty", idx, 32'(bus.empty),    32'(v.exp_empty));
      check("dout",  idx, 32'(bus.dout),     32'(last_dout));
   endtask

   initial begin
      reset     = 1'b1;
      bus.wr    = 1'b0;
      bus.rd    = 1'b0;
      bus.din   = 8'h00;
      last_dout = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_cnt",   0, 32'(bus.fifo_cnt), 32'd0);
      check("rst_empty", 0, 32'(bus.empty),    32'd1);
      check("rst_full",  0, 32'(bus.full),     32'd0);
      check("rst_dout",  0, 32'(bus.dout),     32'd0);

      // Vector table
      add(1'b0, 1'b0, 8'h00, 0);                                     // idle
      for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 8'(i), i);        // fill 1..8
      add(1'b1, 1'b0, 8'hFF, 8);                                     // overflow dropped
      for (int i = 7; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i);        // drain 1..8
      add(1'b0, 1'b1, 8'h00, 0);                                     // underflow ignored
      add(1'b1, 1'b1, 8'hAA, 1);                                     // empty: write only
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'hAA, 1);         // read+write
      add(1'b0, 1'b1, 8'h00, 0);
      for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'(8'h20 + i), i + 1);
      for (int i = 4; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i);
      for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 8'(8'h10 + i), i + 1); // wraps pointers
      add(1'b1, 1'b1, 8'h55, 7);                                     // full: read only
      for (int i = 6; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Asynchronous reset mid-stream with five entries stored
      for (int i = 0; i < 5; i++) apply(mk(1'b1, 1'b0, 8'(8'h40 + i), i + 1), 100 + i);
      @(negedge clk);
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      #2;
      reset = 1'b1;
      #1;   // still well before the next rising edge
      check("arst_cnt",   0, 32'(bus.fifo_cnt), 32'd0);
      check("arst_empty", 0, 32'(bus.empty),    32'd1);
      check("arst_full",  0, 32'(bus.full),     32'd0);
      check("arst_dout",  0, 32'(bus.dout),     32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_q.delete();
      exp_q.delete();
      last_dout = 8'h00;

      // Round trip after reset
      apply(mk(1'b1, 1'b0, 8'h3C, 1), 200);
      apply(mk(1'b0, 1'b1, 8'h00, 0), 201);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
